// File: rtl/divider_seq.sv
// Sequential restoring shift-subtract divider for unsigned N-bit operands.
// St/Idle/Done handshake; divide-by-zero completes in one step with DivZero set.
module divider_seq #(
    parameter int unsigned N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         St,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         Idle,
    output logic         Done,
    output logic         DivZero,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [N:0]    a;
    logic [N-1:0]  q;
    logic [N-1:0]  b;
    logic [CW-1:0] cnt;

    logic          div_zero_c;
    logic          fits_c;
    logic          last_c;
    logic [N:0]    a_sub_c;

    assign div_zero_c = (Divisor == '0);
    assign fits_c     = (a >= {1'b0, b});
    assign a_sub_c    = a - {1'b0, b};
    assign last_c     = (cnt == CW'(N));

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        Idle       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Idle = 1'b1;
                if (St) begin
                    state_next = div_zero_c ? DONE : SHIFT;
                end
            end
            SHIFT: state_next = SUB;
            SUB:   state_next = last_c ? DONE : SHIFT;
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: one shift then one conditional subtract per quotient bit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a         <= '0;
            q         <= '0;
            b         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (St) begin
                        if (div_zero_c) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivZero   <= 1'b1;
                        end else begin
                            a   <= '0;
                            q   <= Dividend;
                            b   <= Divisor;
                            cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    {a, q} <= {a[N-1:0], q, 1'b0};
                    cnt    <= cnt + CW'(1);
                end
                SUB: begin
                    if (fits_c) begin
                        a    <= a_sub_c;
                        q[0] <= 1'b1;
                    end
                    // Final results are taken from the post-subtract values
                    if (last_c) begin
                        Quotient  <= {q[N-1:1], fits_c};
                        Remainder <= fits_c ? a_sub_c[N-1:0] : a[N-1:0];
                        DivZero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
